a2b_serializer: RTL and testbench

Character-to-bit-stream stage that sits directly upstream of the b2a deserializer. It accepts 7-bit ASCII characters over a valid/ready handshake and buffers them in a small FIFO. It emits each character MSB-first, one bit per clk, as a contiguous 7-bit frame. Its out/bit_cnt timing matches the b2a input framing, so out can drive b2a's `in` directly.

---
 rtl/a2b_serializer.sv | 143 ++++++++++++++
 tb/tb_a2b_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2b_serializer.sv
// a2b_serializer: buffers 7-bit characters and streams them MSB-first as contiguous 7-bit frames.
// Define A2B_IDLE_FILL_EN to fill idle time after the first frame with NUL frames.
//
//   state | meaning
//   IDLE  | no frame on the line; waiting for a queued character
//   SHIFT | emitting a frame, bit_cnt 0..6
module a2b_serializer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [6:0]    in_char,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out,
  output logic          out_valid,
  output logic [3:0]    bit_cnt,
  output logic          frame_start,
  output logic [AW:0]   fifo_count,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t          state_q;
  logic [6:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [5:0]      shreg_q;
  logic [3:0]      bit_cnt_q;
  logic            out_q, out_valid_q, frame_start_q, busy_q;

  logic            push, pop, last_bit, next_shift, busy_d;
  logic [6:0]      head;

  assign in_ready = rst_n && (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == 4'd6);
  assign pop      = (count_q != '0) && ((state_q == IDLE) || last_bit);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef A2B_IDLE_FILL_EN
  assign next_shift = pop || (state_q == SHIFT);
`else
  assign next_shift = pop || ((state_q == SHIFT) && !last_bit);
`endif
  assign busy_d = next_shift || (count_d != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // shreg_q holds the bits still to be sent after the one currently on out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      bit_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q       <= SHIFT;
            shreg_q       <= head[5:0];
            out_q         <= head[6];
            out_valid_q   <= 1'b1;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b1;
          end else begin
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shreg_q       <= {shreg_q[4:0], 1'b0};
            out_q         <= shreg_q[5];
            bit_cnt_q     <= bit_cnt_q + 1'b1;
            frame_start_q <= 1'b0;
          end else if (pop) begin
            shreg_q       <= head[5:0];
            out_q         <= head[6];
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b1;
          end else begin
`ifdef A2B_IDLE_FILL_EN
            shreg_q       <= '0;
            out_q         <= 1'b0;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b1;
`else
            state_q       <= IDLE;
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign bit_cnt     = bit_cnt_q;
  assign frame_start = frame_start_q;
  assign fifo_count  = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_a2b_serializer.sv
// tb_a2b_serializer: randomized and directed checks of a2b_serializer against a queue-based
// character/bit-stream reference model.
module tb_a2b_serializer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef A2B_IDLE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [6:0]    in_char = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, out, out_valid, frame_start, busy;
  logic [3:0]    bit_cnt;
  logic [AW:0]   fifo_count;

  a2b_serializer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .bit_cnt(bit_cnt), .frame_start(frame_start),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        out, valid, fs, busy, ready, v;
    logic [3:0]  cnt;
    logic [AW:0] count;
    int          exp_cnt;
  } samp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  samp_t       log_q[$];
  logic [6:0]  acc_q[$];
  int          pushes = 0;
  int          pops = 0;
  logic        acc = 1'b0;

  function automatic logic [6:0] rand_char();
    logic [6:0] c;
    c = 7'($urandom_range(0, 127));
    if (FILL) c[6] = 1'b1;  // lets a real character be told apart from a NUL fill frame
    return c;
  endfunction

  // One clock: sample outputs at the falling edge, then drive the next input.
  task automatic cycle(input logic v, input logic [6:0] c);
    samp_t s;
    @(negedge clk);
    s.out = out; s.valid = out_valid; s.cnt = bit_cnt; s.fs = frame_start;
    s.count = fifo_count; s.busy = busy; s.ready = in_ready;
    if (s.valid && s.fs && (s.out || !FILL)) pops++;
    s.exp_cnt = pushes - pops;
    in_valid = v; in_char = c; s.v = v;
    acc = v && s.ready;
    if (acc) begin acc_q.push_back(c); pushes++; end
    log_q.push_back(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_q.delete(); acc_q.delete();
    pushes = 0; pops = 0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    n_checks++; if (out !== 1'b0)         begin n_fail++; $display("FAIL reset_out: got %b want 0", out); end
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (bit_cnt !== 4'd0)     begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    n_checks++; if (fifo_count !== '0)    begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [6:0] ch;
    logic [6:0] got, exp;
    ch = 7'h48;
    do_reset();
    cycle(1'b1, ch);
    repeat (10) cycle(1'b0, 7'h00);
    n_checks++;
    if ({log_q[1].valid, log_q[1].count} !== {1'b0, 3'd1}) begin
      n_fail++; $display("FAIL single_latency: valid/count %b/%0d want 0/1", log_q[1].valid, log_q[1].count);
    end
    for (int k = 0; k < 7; k++) begin
      got = {log_q[2+k].valid, log_q[2+k].out, log_q[2+k].cnt, log_q[2+k].fs};
      exp = {1'b1, ch[6-k], 4'(k), (k == 0)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL single_bit%0d: {v,out,cnt,fs} got %b want %b", k, got, exp); end
    end
`ifdef A2B_IDLE_FILL_EN
    n_checks++;
    if ({log_q[9].valid, log_q[9].out, log_q[9].fs} !== 3'b101) begin
      n_fail++; $display("FAIL single_fill_after: {v,out,fs} got %b want 101", {log_q[9].valid, log_q[9].out, log_q[9].fs});
    end
`else
    n_checks++;
    if ({log_q[9].valid, log_q[9].busy, log_q[9].count} !== 5'b0) begin
      n_fail++; $display("FAIL single_after: {v,busy,count} got %b want 0", {log_q[9].valid, log_q[9].busy, log_q[9].count});
    end
`endif
  endtask

  task automatic test_burst();
    logic [6:0] hello [5];
    int idx, f;
    logic [6:0] ch;
    logic [2:0] got, exp;
    hello = '{7'h48, 7'h65, 7'h6C, 7'h6C, 7'h6F};
    do_reset();
    idx = 0;
    for (int t = 0; t < 50; t++) begin
      if (idx < 5) cycle(1'b1, hello[idx]); else cycle(1'b0, 7'h00);
      if (acc) idx++;
    end
    n_checks++;
    if (idx !== 5) begin n_fail++; $display("FAIL burst_accepted: got %0d want 5", idx); end
    f = -1;
    for (int i = 0; i < log_q.size(); i++) if (f < 0 && log_q[i].valid) f = i;
    for (int k = 0; k < 35; k++) begin
      ch = hello[k / 7];
      exp = {1'b1, ch[6 - (k % 7)], (k % 7 == 0)};
      if (f < 0 || f + k >= log_q.size()) got = 3'bxxx;
      else got = {log_q[f+k].valid, log_q[f+k].out, log_q[f+k].fs};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL burst_bit%0d: {v,out,fs} got %b want %b", k, got, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] chars [6];
    int idx, f, fp;
    logic [6:0] ch;
    logic [1:0] got, exp;
    for (int i = 0; i < 6; i++) chars[i] = rand_char();
    do_reset();
    idx = 0;
    for (int t = 0; t < 90; t++) begin
      if (idx < 6) cycle(1'b1, chars[idx]); else cycle(1'b0, 7'h00);
      if (acc) idx++;
    end
    n_checks++;
    if (idx !== 6) begin n_fail++; $display("FAIL bp_accepted: got %0d want 6", idx); end
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].count == (AW+1)'(DEPTH)) begin
        n_checks++;
        if (log_q[i].ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: sample %0d ready %b want 0", i, log_q[i].ready); end
      end
    end
    fp = -1;
    for (int i = 0; i + 2 < log_q.size(); i++)
      if (fp < 0 && log_q[i].count == 3'd4 && log_q[i].valid && log_q[i].cnt == 4'd6 && log_q[i].v) fp = i;
    n_checks++;
    if (fp < 0) begin
      n_fail++; $display("FAIL bp_full_pop: got no full+last-bit sample want one");
    end else if ({log_q[fp+1].count, log_q[fp+1].ready, log_q[fp+2].count} !== {3'd3, 1'b1, 3'd4}) begin
      n_fail++; $display("FAIL bp_full_pop: count/ready/count got %0d/%b/%0d want 3/1/4",
                         log_q[fp+1].count, log_q[fp+1].ready, log_q[fp+2].count);
    end
    f = -1;
    for (int i = 0; i < log_q.size(); i++) if (f < 0 && log_q[i].valid) f = i;
    for (int k = 0; k < 42; k++) begin
      ch = chars[k / 7];
      exp = {1'b1, ch[6 - (k % 7)]};
      if (f < 0 || f + k >= log_q.size()) got = 2'bxx;
      else got = {log_q[f+k].valid, log_q[f+k].out};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL bp_bit%0d: {v,out} got %b want %b", k, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [6:0] ch;
    logic [6:0] got, exp;
    do_reset();
    cycle(1'b1, 7'h65); cycle(1'b1, 7'h6C); cycle(1'b1, 7'h6F);
    t = 0;
    while (!(log_q[log_q.size()-1].valid && log_q[log_q.size()-1].cnt == 4'd3) && t < 20) begin
      cycle(1'b0, 7'h00); t++;
    end
    n_checks++;
    if (t >= 20) begin n_fail++; $display("FAIL midrst_reach: got timeout want bit_cnt 3"); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out, out_valid, bit_cnt, frame_start, fifo_count, busy, in_ready} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got out=%b v=%b cnt=%0d fs=%b count=%0d busy=%b rdy=%b want all 0",
                         out, out_valid, bit_cnt, frame_start, fifo_count, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete(); acc_q.delete(); pushes = 0; pops = 0;
    repeat (10) cycle(1'b0, 7'h00);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({log_q[i].valid, log_q[i].busy, log_q[i].count} !== 5'b0) begin
        n_fail++; $display("FAIL midrst_quiet%0d: {v,busy,count} got %b want 0", i, {log_q[i].valid, log_q[i].busy, log_q[i].count});
      end
    end
    ch = 7'h41;
    log_q.delete();
    cycle(1'b1, ch);
    repeat (9) cycle(1'b0, 7'h00);
    for (int k = 0; k < 7; k++) begin
      got = {log_q[2+k].valid, log_q[2+k].out, log_q[2+k].cnt, log_q[2+k].fs};
      exp = {1'b1, ch[6-k], 4'(k), (k == 0)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL midrst_A_bit%0d: {v,out,cnt,fs} got %b want %b", k, got, exp); end
    end
  endtask

  task automatic test_random();
    logic holding;
    logic [6:0] ch;
    samp_t s, p;
    logic [6:0] obs[$];
    logic [6:0] fr;
    int pos;
    do_reset();
    holding = 1'b0; ch = '0;
    for (int t = 0; t < 345; t++) begin
      if (t < 300 && !holding && $urandom_range(0, 2) != 0) begin ch = rand_char(); holding = 1'b1; end
      cycle(holding, ch);
      if (acc) holding = 1'b0;
      s = log_q[log_q.size()-1];
      n_checks++;
      if (s.count !== (AW+1)'(s.exp_cnt)) begin n_fail++; $display("FAIL rnd_count t%0d: got %0d want %0d", t, s.count, s.exp_cnt); end
      n_checks++;
      if (s.ready !== (s.exp_cnt != DEPTH)) begin n_fail++; $display("FAIL rnd_ready t%0d: got %b want %b", t, s.ready, s.exp_cnt != DEPTH); end
      n_checks++;
      if (s.busy !== (s.valid || s.exp_cnt != 0)) begin n_fail++; $display("FAIL rnd_busy t%0d: got %b want %b", t, s.busy, s.valid || s.exp_cnt != 0); end
      if (!s.valid) begin
        n_checks++;
        if (s.out !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_out t%0d: got %b want 0", t, s.out); end
      end
      if (log_q.size() > 1) begin
        p = log_q[log_q.size()-2];
        n_checks++;
        if (p.valid && p.cnt < 4'd6) begin
          if ({s.valid, s.cnt, s.fs} !== {1'b1, p.cnt + 4'd1, 1'b0}) begin
            n_fail++; $display("FAIL rnd_inframe t%0d: {v,cnt,fs} got %b want %b", t, {s.valid, s.cnt, s.fs}, {1'b1, p.cnt + 4'd1, 1'b0});
          end
        end else if ((p.valid && (p.count != 0 || FILL)) || (!p.valid && p.count != 0)) begin
          if ({s.valid, s.cnt, s.fs} !== {1'b1, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL rnd_newframe t%0d: {v,cnt,fs} got %b want %b", t, {s.valid, s.cnt, s.fs}, {1'b1, 4'd0, 1'b1});
          end
        end else begin
          if (s.valid !== 1'b0) begin n_fail++; $display("FAIL rnd_gap t%0d: valid got %b want 0", t, s.valid); end
        end
      end
    end
    pos = -1; fr = '0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].valid && log_q[i].fs) begin pos = 0; fr = '0; end
      if (pos >= 0 && log_q[i].valid) begin
        fr[6-pos] = log_q[i].out;
        pos++;
        if (pos == 7) begin
          if (!(FILL && fr == 7'h00)) obs.push_back(fr);
          pos = -1;
        end
      end
    end
    n_checks++;
    if (obs.size() !== acc_q.size()) begin n_fail++; $display("FAIL rnd_nframes: got %0d want %0d", obs.size(), acc_q.size()); end
    for (int i = 0; i < acc_q.size() && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== acc_q[i]) begin n_fail++; $display("FAIL rnd_frame%0d: got %h want %h", i, obs[i], acc_q[i]); end
    end
  endtask

`ifdef A2B_IDLE_FILL_EN
  task automatic test_idle_fill();
    logic [6:0] ch;
    int f;
    logic [2:0] got, exp;
    ch = 7'h41;
    do_reset();
    cycle(1'b1, ch);
    repeat (35) cycle(1'b0, 7'h00);
    f = -1;
    for (int i = 0; i < log_q.size(); i++) if (f < 0 && log_q[i].valid) f = i;
    for (int k = 0; k < 28; k++) begin
      exp = {1'b1, (k < 7) ? ch[6-k] : 1'b0, (k % 7 == 0)};
      if (f < 0 || f + k >= log_q.size()) got = 3'bxxx;
      else got = {log_q[f+k].valid, log_q[f+k].out, log_q[f+k].fs};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL fill_bit%0d: {v,out,fs} got %b want %b", k, got, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef A2B_IDLE_FILL_EN
    test_idle_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
